// File: rtl/bcd_xs3_seq_if.sv
// Handshake and shared-converter bundle for the BCD to Excess-3 sequencer.
// slave = the sequencer; master = word source, consumer and converter side.
interface bcd_xs3_seq_if #(parameter int NDIG = 4);
  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   bcd_in;
  logic                conv_en;
  logic [3:0]          conv_dig;
  logic [3:0]          conv_res;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   xs3_out;
  logic [NDIG-1:0]     err_mask;

  modport master (
    output in_valid, bcd_in, out_ready, conv_res,
    input  in_ready, conv_en, conv_dig, out_valid, xs3_out, err_mask
  );

  modport slave (
    input  in_valid, bcd_in, out_ready, conv_res,
    output in_ready, conv_en, conv_dig, out_valid, xs3_out, err_mask
  );
endinterface

// File: rtl/bcd_xs3_seq_ctrl.sv
// Packed-BCD to Excess-3 word converter: walks the digits LSD first through one
// shared external 4-bit converter, one digit per clock.

// One result digit plus its error flag; cleared on word accept, written once in CONV.
module bcd_xs3_digit_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr,
  input  logic       bad,
  input  logic [3:0] res,
  output logic [3:0] q,
  output logic       err
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= 4'd0;
      err <= 1'b0;
    end else if (wr) begin
      q   <= bad ? 4'd0 : res;
      err <= bad;
    end
  end
endmodule

module bcd_xs3_seq_ctrl #(
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst,
  bcd_xs3_seq_if.slave  bus
);
  localparam int              IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [IDXW-1:0]       idx;
  logic [NDIG-1:0][3:0]  word;
  logic [NDIG-1:0][3:0]  res;
  logic [NDIG-1:0]       err;
  logic                  accept;
  logic                  in_conv;
  logic [3:0]            dig;
  logic                  dig_bad;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign in_conv = (state == CONV);
  // Converter is fed from the latched word only, never straight from bcd_in.
  assign dig     = word[idx];
  assign dig_bad = (dig > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          word  <= bus.bcd_in;
          idx   <= '0;
          state <= CONV;
        end
        CONV: if (idx == LAST) begin
          idx   <= '0;
          state <= DONE;
        end else begin
          idx <= idx + 1'b1;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    bcd_xs3_digit_slot u_slot (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .wr  (in_conv && (idx == IDXW'(k))),
      .bad (dig_bad),
      .res (bus.conv_res),
      .q   (res[k]),
      .err (err[k])
    );
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.conv_en   = in_conv;
  assign bus.conv_dig  = in_conv ? dig : 4'd0;
  assign bus.xs3_out   = res;
  assign bus.err_mask  = err;
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Bench for bcd_xs3_seq_ctrl (NDIG=4) with a real +3 converter on the shared port.
module tb_bcd_xs3_seq_ctrl;
  localparam int NDIG = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_xs3_seq_if #(.NDIG(NDIG)) bus ();

  bcd_xs3_seq_ctrl #(.NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.conv_res = bus.conv_dig + 4'd3;

  function automatic logic [15:0] model_xs3(input logic [15:0] w);
    logic [15:0] r;
    int d;
    r = '0;
    for (int k = 0; k < NDIG; k++) begin
      d = int'(w[4*k +: 4]);
      r[4*k +: 4] = (d > 9) ? 4'd0 : 4'(d + 3);
    end
    return r;
  endfunction

  function automatic logic [3:0] model_err(input logic [15:0] w);
    logic [3:0] e;
    for (int k = 0; k < NDIG; k++) e[k] = (int'(w[4*k +: 4]) > 9);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.conv_en !== 1'b0 ||
        bus.conv_dig !== 4'd0 || bus.xs3_out !== 16'd0 || bus.err_mask !== 4'd0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b conv_en=%b conv_dig=%h xs3=%h err=%b want 1 0 0 0 0000 0000",
               bus.in_ready, bus.out_valid, bus.conv_en, bus.conv_dig, bus.xs3_out, bus.err_mask);
    end
  endtask

  // Full word transaction from IDLE with out_ready=1.
  task automatic test_word(input logic [15:0] w);
    logic [15:0] ex;
    logic [3:0]  em;
    ex = model_xs3(w);
    em = model_err(w);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL word %h idle: in_ready=%b want 1", w, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bcd_in   = 16'($urandom);
    for (int k = 0; k < NDIG; k++) begin
      total++;
      if (bus.conv_en !== 1'b1 || bus.conv_dig !== w[4*k +: 4] || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL word %h conv%0d: conv_en=%b conv_dig=%h in_ready=%b out_valid=%b want 1 %h 0 0",
                 w, k, bus.conv_en, bus.conv_dig, bus.in_ready, bus.out_valid, w[4*k +: 4]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.xs3_out !== ex || bus.err_mask !== em ||
        bus.conv_en !== 1'b0 || bus.conv_dig !== 4'd0) begin
      bad++;
      $display("FAIL word %h done: out_valid=%b xs3=%h err=%b conv_en=%b conv_dig=%h want 1 %h %b 0 0",
               w, bus.out_valid, bus.xs3_out, bus.err_mask, bus.conv_en, bus.conv_dig, ex, em);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.xs3_out !== ex || bus.err_mask !== em) begin
      bad++;
      $display("FAIL word %h hold: out_valid=%b in_ready=%b xs3=%h err=%b want 0 1 %h %b",
               w, bus.out_valid, bus.in_ready, bus.xs3_out, bus.err_mask, ex, em);
    end
  endtask

  task automatic test_vectors();
    test_word(16'h1234);
    test_word(16'h9009);
    test_word(16'h0000);
    test_word(16'h0A5F);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < NDIG; k++)
        w[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      test_word(w);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] wa, wb;
    wa = 16'h2468;
    wb = 16'h1357;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = wa;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (NDIG) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = wb;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.xs3_out !== model_xs3(wa) ||
          bus.err_mask !== model_err(wa) || bus.conv_en !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: out_valid=%b in_ready=%b xs3=%h err=%b conv_en=%b want 1 0 %h %b 0",
                 i, bus.out_valid, bus.in_ready, bus.xs3_out, bus.err_mask, bus.conv_en,
                 model_xs3(wa), model_err(wa));
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.conv_en !== 1'b0) begin
      bad++;
      $display("FAIL release: in_ready=%b out_valid=%b conv_en=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.conv_en);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      total++;
      if (bus.conv_en !== 1'b1 || bus.conv_dig !== wb[4*k +: 4]) begin
        bad++;
        $display("FAIL second word conv%0d: conv_en=%b conv_dig=%h want 1 %h",
                 k, bus.conv_en, bus.conv_dig, wb[4*k +: 4]);
      end
      @(negedge clk);
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.xs3_out !== model_xs3(wb) || bus.err_mask !== model_err(wb)) begin
      bad++;
      $display("FAIL second word done: out_valid=%b xs3=%h err=%b want 1 %h %b",
               bus.out_valid, bus.xs3_out, bus.err_mask, model_xs3(wb), model_err(wb));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 16'h5678;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.conv_en !== 1'b0 ||
        bus.conv_dig !== 4'd0 || bus.xs3_out !== 16'd0 || bus.err_mask !== 4'd0) begin
      bad++;
      $display("FAIL mid reset: in_ready=%b out_valid=%b conv_en=%b conv_dig=%h xs3=%h err=%b want 1 0 0 0 0000 0000",
               bus.in_ready, bus.out_valid, bus.conv_en, bus.conv_dig, bus.xs3_out, bus.err_mask);
    end
    test_word(16'h0001);
  endtask

  task automatic test_back_to_back();
    int          npulse;
    int          pcyc[2];
    logic [15:0] pval[2];
    logic [3:0]  perr[2];
    npulse = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 16'h0123;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.bcd_in = 16'h4567;
      if (bus.out_valid === 1'b1) begin
        if (npulse < 2) begin
          pcyc[npulse] = cyc;
          pval[npulse] = bus.xs3_out;
          perr[npulse] = bus.err_mask;
        end
        npulse++;
        if (npulse == 2) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (npulse !== 2) begin
      bad++;
      $display("FAIL b2b pulses: got %0d want 2", npulse);
    end else begin
      total++;
      if (pval[0] !== model_xs3(16'h0123) || pval[1] !== model_xs3(16'h4567) ||
          perr[0] !== 4'd0 || perr[1] !== 4'd0) begin
        bad++;
        $display("FAIL b2b results: %h/%b %h/%b want %h/0000 %h/0000", pval[0], perr[0], pval[1], perr[1],
                 model_xs3(16'h0123), model_xs3(16'h4567));
      end
      total++;
      if (pcyc[1] - pcyc[0] !== NDIG + 2) begin
        bad++;
        $display("FAIL b2b spacing: got %0d want %0d", pcyc[1] - pcyc[0], NDIG + 2);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
